// File: rtl/demux_stream_2.sv
`default_nettype none
// ============================================================================
//  Module   : demux_stream_2
//  Purpose  : 1-to-2 stream demultiplexer. Each input word is steered by cs
//             into one of two independent 2-entry output FIFOs; each output
//             port keeps a wrapping count of completed transfers.
//  Revision : 1.0  initial release
// ============================================================================
module demux_stream_2 #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cs,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNTW-1:0]  out1_cnt,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNTW-1:0]  out2_cnt
);

  // Per-port views; index 0 is out1, index 1 is out2.
  logic [1:0][WIDTH-1:0] q_data;
  logic [1:0][CNTW-1:0]  q_cnt;
  logic [1:0]            q_valid;
  logic [1:0]            q_full;
  logic [1:0]            q_ready;
  logic [1:0]            q_push;

  assign q_ready = {out2_ready, out1_ready};

  // Acceptance looks only at the selected queue's occupancy, never at the
  // sink's ready, so a full queue cannot pass a word straight through.
  always_comb begin
    in_ready  = cs ? ~q_full[1] : ~q_full[0];
    q_push[0] = in_valid & in_ready & ~cs;
    q_push[1] = in_valid & in_ready & cs;
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    logic [WIDTH-1:0] mem [2];
    logic             wptr;
    logic             rptr;
    logic [1:0]       occ;
    logic [CNTW-1:0]  cnt;
    logic             pop;

    assign pop        = (occ != 2'd0) & q_ready[i];
    assign q_valid[i] = (occ != 2'd0);
    assign q_full[i]  = (occ == 2'd2);
    assign q_data[i]  = mem[rptr];
    assign q_cnt[i]   = cnt;

    // Queue storage, pointers, occupancy and transfer counter; reset clears
    // everything at once so no stale word survives a mid-stream reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[0] <= '0;
        mem[1] <= '0;
        wptr   <= 1'b0;
        rptr   <= 1'b0;
        occ    <= 2'd0;
        cnt    <= '0;
      end else begin
        if (q_push[i]) begin
          mem[wptr] <= in_data;
          wptr      <= ~wptr;
        end
        if (pop) begin
          rptr <= ~rptr;
          cnt  <= cnt + 1'b1;
        end
        case ({q_push[i], pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  assign out1_data  = q_data[0];
  assign out1_valid = q_valid[0];
  assign out1_cnt   = q_cnt[0];
  assign out2_data  = q_data[1];
  assign out2_valid = q_valid[1];
  assign out2_cnt   = q_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_stream_2
//  Purpose  : Self-checking bench for demux_stream_2 using a queue-based
//             reference model, directed scenarios and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_stream_2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        cs, in_valid, in_ready;
  logic [31:0] out1_data, out2_data;
  logic        out1_valid, out2_valid, out1_ready, out2_ready;
  logic [15:0] out1_cnt, out2_cnt;

  // Narrow-counter instance for the wrap check
  logic [7:0]  s_in_data, s_out1_data, s_out2_data;
  logic        s_cs, s_in_valid, s_in_ready;
  logic        s_out1_valid, s_out2_valid, s_out1_ready, s_out2_ready;
  logic [3:0]  s_out1_cnt, s_out2_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per port plus transfer counters
  logic [31:0] mq1[$];
  logic [31:0] mq2[$];
  logic [15:0] mc1, mc2;

  always #5 clk = ~clk;

  demux_stream_2 #(.WIDTH(32), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .cs(cs),
    .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_cnt(out1_cnt),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out2_cnt(out2_cnt)
  );

  demux_stream_2 #(.WIDTH(8), .CNTW(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .cs(s_cs),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out1_data(s_out1_data), .out1_valid(s_out1_valid),
    .out1_ready(s_out1_ready), .out1_cnt(s_out1_cnt),
    .out2_data(s_out2_data), .out2_valid(s_out2_valid),
    .out2_ready(s_out2_ready), .out2_cnt(s_out2_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input logic r1, input logic r2);
    in_valid   = v;
    cs         = s;
    in_data    = d;
    out1_ready = r1;
    out2_ready = r2;
  endtask

  // Called just after a falling edge with inputs already driven: checks the
  // DUT against the model, then advances the model across the next rising edge.
  task automatic cycle();
    logic exp_ready, acc, p1, p2;
    #1;
    exp_ready = cs ? (mq2.size() < 2) : (mq1.size() < 2);
    check("in_ready", in_ready, exp_ready);
    check("out1_valid", out1_valid, mq1.size() != 0);
    check("out2_valid", out2_valid, mq2.size() != 0);
    if (mq1.size() != 0) check("out1_data", out1_data, mq1[0]);
    if (mq2.size() != 0) check("out2_data", out2_data, mq2[0]);
    check("out1_cnt", out1_cnt, mc1);
    check("out2_cnt", out2_cnt, mc2);
    acc = in_valid && exp_ready;
    p1  = (mq1.size() != 0) && out1_ready;
    p2  = (mq2.size() != 0) && out2_ready;
    @(posedge clk);
    if (p1) begin void'(mq1.pop_front()); mc1 = mc1 + 16'd1; end
    if (p2) begin void'(mq2.pop_front()); mc2 = mc2 + 16'd1; end
    if (acc) begin
      if (cs) mq2.push_back(in_data);
      else    mq1.push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic clear_model();
    mq1.delete();
    mq2.delete();
    mc1 = '0;
    mc2 = '0;
  endtask

  initial begin
    clear_model();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    s_in_valid = 1'b0; s_cs = 1'b0; s_in_data = 8'h0;
    s_out1_ready = 1'b0; s_out2_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out1_data", out1_data, 32'h0);
    check("reset_out2_valid", out2_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word through port 1
    drive(1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);        cycle();
    cycle();
    check("single_cnt1", out1_cnt, 16'd1);
    check("single_valid2", out2_valid, 1'b0);

    // Port 2 backpressure: third word waits at the input
    drive(1'b1, 1'b1, 32'hA, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'hB, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'hC, 1'b0, 1'b0); cycle(); cycle();
    check("bp_stalled", in_ready, 1'b0);
    // cs flip while port 2 is full lands the word in port 1
    drive(1'b1, 1'b0, 32'hD, 1'b0, 1'b0); #1;
    check("cs_flip_ready", in_ready, 1'b1);
    cycle();
    drive(1'b1, 1'b1, 32'hC, 1'b0, 1'b1); cycle(); cycle();
    drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    repeat (4) cycle();
    check("bp_cnt2", out2_cnt, 16'd3);

    // Port 1 at one entry, simultaneous push and pop for 10 cycles
    drive(1'b1, 1'b0, 32'h100, 1'b0, 1'b0); cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 32'h200 + k, 1'b1, 1'b0); cycle();
    end
    check("stream_occ1", 32'(mq1.size()), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); cycle(); cycle();

    // Fill both queues, then pulse reset between edges
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k[0], 32'hF0 + k, 1'b0, 1'b0); cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out1_valid", out1_valid, 1'b0);
    check("arst_out2_valid", out2_valid, 1'b0);
    check("arst_out1_data", out1_data, 32'h0);
    check("arst_out2_data", out2_data, 32'h0);
    check("arst_cnt1", out1_cnt, 16'h0);
    check("arst_in_ready", in_ready, 1'b1);
    clear_model();
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); cycle(); cycle();

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (3) cycle();

    // Counter wrap on the narrow instance: 17 transfers -> 1
    s_out1_ready = 1'b1;
    s_in_valid   = 1'b1;
    for (int k = 0; k < 17; k++) begin
      s_in_data = 8'(k);
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wrap_cnt", s_out1_cnt, 4'd1);
    check("wrap_valid", s_out1_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
